// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit bit stuffer.
`timescale 1ns/1ps
package usb_tx_pkg;

  localparam int MAX_ONES_DEF = 6;

  // Line states as {dp, dm}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STUFF,
    ST_SE0_1,
    ST_SE0_2,
    ST_J_EOP
  } tx_stuff_state_t;

endpackage

// File: rtl/usb_nrzi_encoder.sv
// Registered NRZI line driver: a 0 toggles the level, a 1 holds it.
// force_j also restores the idle level so the next packet starts from J.
`timescale 1ns/1ps
module usb_nrzi_encoder
  import usb_tx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic i_tick,
  input  logic i_encode,
  input  logic i_bit,
  input  logic i_force_j,
  input  logic i_force_se0,
  output logic dp_out,
  output logic dm_out
);

  logic       r_level;
  logic [1:0] r_line;
  logic       w_next_level;

  assign w_next_level = i_bit ? r_level : ~r_level;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_level <= 1'b1;
      r_line  <= LINE_J;
    end else if (i_tick) begin
      if (i_force_j) begin
        r_level <= 1'b1;
        r_line  <= LINE_J;
      end else if (i_force_se0) begin
        r_line <= LINE_SE0;
      end else if (i_encode) begin
        r_level <= w_next_level;
        r_line  <= w_next_level ? LINE_J : LINE_K;
      end
    end
  end

  assign dp_out = r_line[1];
  assign dm_out = r_line[0];

endmodule

// File: rtl/usb_tx_bit_stuffer.sv
// USB transmit bit stuffer: inserts a 0 after MAX_ONES consecutive 1s,
// NRZI-encodes the stream and appends SE0,SE0,J on end-of-packet request.
`timescale 1ns/1ps
module usb_tx_bit_stuffer
  import usb_tx_pkg::*;
#(
  parameter int MAX_ONES = MAX_ONES_DEF,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic bit_tick,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic eop_req,
  output logic bit_taken,
  output logic dp_out,
  output logic dm_out,
  output logic tx_busy,
  output logic stuffing,
  output logic eop_done,
  output logic underrun
);

  tx_stuff_state_t r_state, w_state_next;
  logic [CNT_W-1:0] r_ones_cnt, w_cnt_next, w_cnt_take;
  logic r_bit_taken, r_eop_done, r_underrun;
  logic w_take, w_encode, w_enc_bit, w_force_j, w_force_se0, w_eop_done, w_underrun;

  // Count the incoming bit would produce if consumed this tick
  assign w_cnt_take = bit_in ? (r_ones_cnt + CNT_W'(1)) : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_ones_cnt <= '0;
    end else if (bit_tick) begin
      r_state    <= w_state_next;
      r_ones_cnt <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_DATA: begin
        if (bit_valid)
          w_state_next = (w_cnt_take == CNT_W'(MAX_ONES)) ? ST_STUFF : ST_DATA;
        else if (eop_req)
          w_state_next = ST_SE0_1;
      end
      ST_STUFF: w_state_next = ST_DATA;
      ST_SE0_1: w_state_next = ST_SE0_2;
      ST_SE0_2: w_state_next = ST_J_EOP;
      ST_J_EOP: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_take      = 1'b0;
    w_encode    = 1'b0;
    w_enc_bit   = 1'b0;
    w_force_j   = 1'b0;
    w_force_se0 = 1'b0;
    w_eop_done  = 1'b0;
    w_underrun  = 1'b0;
    w_cnt_next  = r_ones_cnt;
    case (r_state)
      ST_IDLE, ST_DATA: begin
        if (bit_valid) begin
          w_take     = 1'b1;
          w_encode   = 1'b1;
          w_enc_bit  = bit_in;
          w_cnt_next = w_cnt_take;
        end else if (eop_req) begin
          w_force_se0 = 1'b1;
        end else if (r_state == ST_DATA) begin
          w_underrun = 1'b1;
        end
      end
      ST_STUFF: begin
        w_encode   = 1'b1;
        w_cnt_next = '0;
      end
      ST_SE0_1: w_force_se0 = 1'b1;
      ST_SE0_2: w_force_j   = 1'b1;
      ST_J_EOP: begin
        w_force_j  = 1'b1;
        w_eop_done = 1'b1;
        w_cnt_next = '0;
      end
      default: w_cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_bit_taken <= 1'b0;
      r_eop_done  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_bit_taken <= bit_tick & w_take;
      r_eop_done  <= bit_tick & w_eop_done;
      r_underrun  <= bit_tick & w_underrun;
    end
  end

  usb_nrzi_encoder u_nrzi (
    .clk         (clk),
    .n_rst       (n_rst),
    .i_tick      (bit_tick),
    .i_encode    (w_encode),
    .i_bit       (w_enc_bit),
    .i_force_j   (w_force_j),
    .i_force_se0 (w_force_se0),
    .dp_out      (dp_out),
    .dm_out      (dm_out)
  );

  assign bit_taken = r_bit_taken;
  assign eop_done  = r_eop_done;
  assign underrun  = r_underrun;
  assign tx_busy   = (r_state != ST_IDLE);
  assign stuffing  = (r_state == ST_STUFF);

endmodule
